mem_store_buffer: RTL and testbench

//  Memory-stage store buffer between the M-stage pipeline register outputs and the single-port data memory.
//  - Stores retire into a small FIFO in one cycle; the FIFO drains to memory in the background.
//  - Loads are serviced by youngest-match forwarding from the FIFO, or by a memory read.
//  - stall_m goes to the hazard unit and freezes F/D/E/M while a store or load cannot complete.

---
 rtl/mem_store_buffer_if.sv | 33 +++
 rtl/mem_store_buffer.sv | 142 ++++++++++++++
 tb/tb_mem_store_buffer.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_store_buffer_if.sv
// Signal bundle for the M-stage store buffer: pipeline-side load/store inputs and results,
// plus the single-port data-memory request bus. master = store buffer, slave = environment.
interface mem_store_buffer_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          memwrite_m;
   logic          memread_m;
   logic [AW-1:0] address_m;
   logic [DW-1:0] writedata_m;
   logic [DW-1:0] readdata_m;
   logic          stall_m;
   logic          sb_empty;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;
   logic [1:0]    sb_state;

   // Memory handshake: mem_req/mem_we/mem_addr/mem_wdata stay stable from issue until the first
   // cycle mem_ready is high; that cycle completes the transfer and carries mem_rdata for reads.
   modport master (
      input  memwrite_m, memread_m, address_m, writedata_m, mem_rdata, mem_ready,
      output readdata_m, stall_m, sb_empty, mem_req, mem_we, mem_addr, mem_wdata, sb_state
   );

   modport slave (
      output memwrite_m, memread_m, address_m, writedata_m, mem_rdata, mem_ready,
      input  readdata_m, stall_m, sb_empty, mem_req, mem_we, mem_addr, mem_wdata, sb_state
   );
endinterface

// File: rtl/mem_store_buffer.sv
// M-stage store buffer: stores retire into a FIFO that drains to memory in the background.
// Define SB_STORE_FORWARD_EN to let loads forward from buffered stores instead of waiting for drain.
module mem_store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   mem_store_buffer_if.master     bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = AW - 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_t;

   state_t        state_q;
   logic [TW-1:0] tag_q  [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          mem_req_q;
   logic          mem_we_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q;

   logic          full, empty;
   logic          store_req, load_req;
   logic          enq, deq, read_done;
   logic          load_hit, go_read;
   logic [DW-1:0] fwd_data;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   // A simultaneous store and load is illegal; the store wins and the load is ignored.
   assign store_req = bus.memwrite_m;
   assign load_req  = bus.memread_m & ~bus.memwrite_m;
   assign enq       = store_req & ~full;
   assign deq       = (state_q == WRITE) & bus.mem_ready;
   assign read_done = (state_q == READ) & bus.mem_ready;

`ifdef SB_STORE_FORWARD_EN
   // Walk oldest to youngest so the youngest matching entry overrides older ones.
   always_comb begin
      load_hit = 1'b0;
      fwd_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (load_req && (CW'(k) < count_q) &&
             (tag_q[rd_ptr_q + PW'(k)] == bus.address_m[AW-1:2])) begin
            load_hit = 1'b1;
            fwd_data = data_q[rd_ptr_q + PW'(k)];
         end
      end
   end

   assign go_read = load_req & ~load_hit;
`else
   assign load_hit = 1'b0;
   assign fwd_data = '0;
   // Without forwarding a load may only read memory once every older store has drained.
   assign go_read  = load_req & empty;
`endif

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      if (enq && !deq)      count_d = count_q + CW'(1);
      else if (!enq && deq) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         tag_q[wr_ptr_q]  <= bus.address_m[AW-1:2];
         data_q[wr_ptr_q] <= bus.writedata_m;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         case (state_q)
            IDLE: begin
               if (go_read) begin
                  state_q    <= READ;
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= {bus.address_m[AW-1:2], 2'b00};
               end else if (!empty) begin
                  state_q     <= WRITE;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= {tag_q[rd_ptr_q], 2'b00};
                  mem_wdata_q <= data_q[rd_ptr_q];
               end
            end
            WRITE, READ: begin
               if (bus.mem_ready) begin
                  state_q   <= IDLE;
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // A missing load is released in the very cycle its read data returns.
   assign bus.stall_m    = (store_req & full) | (load_req & ~load_hit & ~read_done);
   assign bus.readdata_m = load_hit  ? fwd_data :
                           read_done ? bus.mem_rdata : '0;
   assign bus.sb_empty   = empty;
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.sb_state   = state_q;

   a_no_store_and_load: assert property (@(posedge clk) disable iff (!reset)
      !(bus.memwrite_m && bus.memread_m));

endmodule

// File: tb/tb_mem_store_buffer.sv
// Self-checking bench for mem_store_buffer: directed scenarios plus a write scoreboard on the memory bus.
module tb_mem_store_buffer;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [AW+DW-1:0] exp_q [$];
   logic [AW+DW-1:0] exp_w;
   logic [DW-1:0]    mem_model [logic [AW-1:0]];

   always #5 clk = ~clk;

   mem_store_buffer_if #(.AW(AW), .DW(DW)) bus ();

   mem_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   function automatic logic [DW-1:0] mem_default(input logic [AW-1:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Memory model: read data follows the registered address shortly after each rising edge.
   always @(posedge clk) begin
      #2;
      if (mem_model.exists(bus.mem_addr)) bus.mem_rdata = mem_model[bus.mem_addr];
      else                                bus.mem_rdata = mem_default(bus.mem_addr);
   end

   // Scoreboard: every completed memory write must match the oldest outstanding store.
   always @(negedge clk) begin
      if (reset && bus.mem_req && bus.mem_we && bus.mem_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_write_unexpected: got addr=%h data=%h, want no write", bus.mem_addr, bus.mem_wdata);
         end else begin
            exp_w = exp_q.pop_front();
            if ({bus.mem_addr, bus.mem_wdata} !== exp_w) begin
               errors++;
               $display("FAIL sb_write: got addr=%h data=%h, want addr=%h data=%h",
                        bus.mem_addr, bus.mem_wdata, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
            end
         end
         mem_model[bus.mem_addr] = bus.mem_wdata;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.memwrite_m  = 1'b0;
      bus.memread_m   = 1'b0;
      bus.address_m   = '0;
      bus.writedata_m = '0;
   endtask

   task automatic store_drive(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.memwrite_m  = 1'b1;
      bus.memread_m   = 1'b0;
      bus.address_m   = a;
      bus.writedata_m = d;
      exp_q.push_back({a[AW-1:2], 2'b00, d});
   endtask

   task automatic wait_drain(input string name);
      bit done = 1'b0;
      bus.mem_ready = 1'b1;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (bus.sb_empty && !bus.mem_req && exp_q.size() == 0) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_drain: sb_empty=%0b mem_req=%0b pending=%0d, want drained",
                  name, bus.sb_empty, bus.mem_req, exp_q.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle_inputs();
      bus.mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.sb_empty !== 1'b1) begin errors++; $display("FAIL reset_sb_empty: got %0b, want 1", bus.sb_empty); end
      checks++;
      if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0b, want 0", bus.mem_req); end
      checks++;
      if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %0b, want 0", bus.mem_we); end
      checks++;
      if (bus.stall_m !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b, want 0", bus.stall_m); end
      checks++;
      if ({bus.mem_addr, bus.mem_wdata, bus.readdata_m} !== '0) begin
         errors++;
         $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, want all 0", bus.mem_addr, bus.mem_wdata, bus.readdata_m);
      end
      checks++;
      if (bus.sb_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d, want 0", bus.sb_state); end
      tick();
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.mem_req !== 1'b0 || bus.sb_empty !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_idle: got mem_req=%0b sb_empty=%0b, want 0/1", bus.mem_req, bus.sb_empty);
      end
   endtask

   task automatic test_single_store();
      bus.mem_ready = 1'b1;
      tick();
      store_drive(32'h100, 32'hDEAD_BEEF);
      @(negedge clk);
      checks++;
      if (bus.stall_m !== 1'b0) begin errors++; $display("FAIL single_stall: got %0b, want 0", bus.stall_m); end
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
      if (bus.sb_empty !== 1'b0 || bus.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL single_enqueued: got sb_empty=%0b mem_req=%0b, want 0/0", bus.sb_empty, bus.mem_req);
      end
      tick();
      @(negedge clk);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_wdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL single_write: got req=%0b we=%0b addr=%h data=%h, want 1 1 00000100 deadbeef",
                  bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      tick();
      @(negedge clk);
      checks++;
      if (bus.sb_empty !== 1'b1 || bus.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL single_done: got sb_empty=%0b mem_req=%0b, want 1/0", bus.sb_empty, bus.mem_req);
      end
      wait_drain("single");
   endtask

   task automatic test_full_stall();
      bit released = 1'b0;
      logic want;
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         store_drive(32'h400 + 32'(4 * i), $urandom);
         @(negedge clk);
         want = (i == 4);
         checks++;
         if (bus.stall_m !== want) begin errors++; $display("FAIL full_store%0d_stall: got %0b, want %0b", i, bus.stall_m, want); end
      end
      repeat (2) begin
         tick();
         @(negedge clk);
         checks++;
         if (bus.stall_m !== 1'b1) begin errors++; $display("FAIL full_hold_stall: got %0b, want 1", bus.stall_m); end
      end
      tick();
      bus.mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.stall_m !== 1'b1) begin errors++; $display("FAIL full_no_bypass: got stall %0b, want 1", bus.stall_m); end
      tick();
      bus.mem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.stall_m !== 1'b0) begin errors++; $display("FAIL full_after_deq: got stall %0b, want 0", bus.stall_m); end
      tick();
      store_drive(32'h414, $urandom);
      @(negedge clk);
      checks++;
      if (bus.stall_m !== 1'b1) begin errors++; $display("FAIL full_refilled: got stall %0b, want 1", bus.stall_m); end
      tick();
      bus.mem_ready = 1'b1;
      for (int c = 0; c < 20 && !released; c++) begin
         @(negedge clk);
         if (!bus.stall_m) released = 1'b1;
         else tick();
      end
      checks++;
      if (!released) begin errors++; $display("FAIL full_release: stall stuck at 1, want 0 within 20 cycles"); end
      tick();
      idle_inputs();
      wait_drain("full");
   endtask

   task automatic test_forward();
      bus.mem_ready = 1'b0;
      tick(); store_drive(32'h200, 32'd1);
      tick(); store_drive(32'h200, 32'd2);
      tick(); store_drive(32'h204, 32'd7);
      tick();
      idle_inputs();
      bus.memread_m = 1'b1;
      bus.address_m = 32'h202;
`ifdef SB_STORE_FORWARD_EN
      @(negedge clk);
      checks++;
      if (bus.readdata_m !== 32'd2 || bus.stall_m !== 1'b0) begin
         errors++;
         $display("FAIL fwd_youngest: got data=%h stall=%0b, want 00000002/0", bus.readdata_m, bus.stall_m);
      end
      tick();
      bus.address_m = 32'h204;
      @(negedge clk);
      checks++;
      if (bus.readdata_m !== 32'd7 || bus.stall_m !== 1'b0) begin
         errors++;
         $display("FAIL fwd_other: got data=%h stall=%0b, want 00000007/0", bus.readdata_m, bus.stall_m);
      end
`else
      begin
         bit released = 1'b0;
         @(negedge clk);
         checks++;
         if (bus.stall_m !== 1'b1) begin errors++; $display("FAIL nofwd_stall: got %0b, want 1", bus.stall_m); end
         tick();
         bus.mem_ready = 1'b1;
         for (int c = 0; c < 40 && !released; c++) begin
            @(negedge clk);
            if (!bus.stall_m) released = 1'b1;
            else tick();
         end
         checks++;
         if (!released || bus.readdata_m !== 32'd2 || bus.sb_empty !== 1'b1) begin
            errors++;
            $display("FAIL nofwd_read: got released=%0b data=%h sb_empty=%0b, want 1/00000002/1",
                     released, bus.readdata_m, bus.sb_empty);
         end
      end
`endif
      tick();
      idle_inputs();
      wait_drain("forward");
   endtask

   task automatic test_load_miss();
      bus.mem_ready = 1'b0;
      tick();
      store_drive(32'h500, $urandom);
      tick();
      idle_inputs();
      bus.memread_m = 1'b1;
      bus.address_m = 32'h300;
`ifdef SB_STORE_FORWARD_EN
      begin
         int stall_cycles = 0;
         @(negedge clk);
         if (bus.stall_m) stall_cycles++;
         tick();
         @(negedge clk);
         if (bus.stall_m) stall_cycles++;
         checks++;
         if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h300) begin
            errors++;
            $display("FAIL miss_read_first: got req=%0b we=%0b addr=%h, want 1 0 00000300", bus.mem_req, bus.mem_we, bus.mem_addr);
         end
         tick();
         @(negedge clk);
         if (bus.stall_m) stall_cycles++;
         tick();
         bus.mem_ready = 1'b1;
         @(negedge clk);
         checks++;
         if (bus.stall_m !== 1'b0 || bus.readdata_m !== mem_default(32'h300)) begin
            errors++;
            $display("FAIL miss_data: got stall=%0b data=%h, want 0/%h", bus.stall_m, bus.readdata_m, mem_default(32'h300));
         end
         checks++;
         if (stall_cycles != 3) begin errors++; $display("FAIL miss_stall_cycles: got %0d, want 3", stall_cycles); end
      end
`else
      begin
         bit released = 1'b0;
         @(negedge clk);
         checks++;
         if (bus.stall_m !== 1'b1) begin errors++; $display("FAIL miss_stall: got %0b, want 1", bus.stall_m); end
         tick();
         @(negedge clk);
         checks++;
         if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin
            errors++;
            $display("FAIL miss_drain_first: got req=%0b we=%0b, want 1 1", bus.mem_req, bus.mem_we);
         end
         tick();
         bus.mem_ready = 1'b1;
         for (int c = 0; c < 40 && !released; c++) begin
            @(negedge clk);
            if (!bus.stall_m) released = 1'b1;
            else tick();
         end
         checks++;
         if (!released || bus.readdata_m !== mem_default(32'h300)) begin
            errors++;
            $display("FAIL miss_data: got released=%0b data=%h, want 1/%h", released, bus.readdata_m, mem_default(32'h300));
         end
      end
`endif
      tick();
      idle_inputs();
      wait_drain("miss");
   endtask

   task automatic test_reset_mid_write();
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         store_drive(32'h600 + 32'(4 * i), $urandom);
      end
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.sb_empty !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_pre: got req=%0b we=%0b sb_empty=%0b, want 1 1 0", bus.mem_req, bus.mem_we, bus.sb_empty);
      end
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (bus.mem_req !== 1'b0 || bus.sb_empty !== 1'b1 || bus.stall_m !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_immediate: got req=%0b sb_empty=%0b stall=%0b, want 0 1 0", bus.mem_req, bus.sb_empty, bus.stall_m);
      end
      exp_q.delete();
      bus.mem_ready = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      repeat (8) tick();
      @(negedge clk);
      checks++;
      if (bus.mem_req !== 1'b0 || bus.sb_empty !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_after: got req=%0b sb_empty=%0b, want 0 1", bus.mem_req, bus.sb_empty);
      end
   endtask

   initial begin
      idle_inputs();
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      test_reset();
      test_single_store();
      test_full_stall();
      test_forward();
      test_load_miss();
      test_reset_mid_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
